// File: rtl/btn_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// btn_debounce: synchronises a raw push-button and debounces it into a
// registered level with one-cycle press/release pulses.
// Optional macro LONG_PRESS_EN adds a one-cycle long_press pulse.
// Revision: 1.0
// ============================================================================
module btn_debounce #(
  parameter int SYNC_STAGES       = 2,
  parameter int DEBOUNCE_CYCLES   = 16,
  parameter int LONG_PRESS_CYCLES = 64
) (
  input  logic clk,
  input  logic rstbtn_n,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release,
  output logic long_press
);

  localparam int CNT_W  = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W = $clog2(LONG_PRESS_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync_out;
  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   press_q, press_d;
  logic                   release_q, release_d;

  always_comb sync_d = {sync_q[SYNC_STAGES-2:0], btn_raw};
  assign sync_out = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    case (state_q)
      IDLE: begin
        level_d = 1'b0;
        if (sync_out) begin
          state_d = PRESS_WAIT;
          cnt_d   = '0;
        end
      end
      PRESS_WAIT: begin
        level_d = 1'b0;
        if (!sync_out) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRESSED;
          cnt_d   = '0;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      PRESSED: begin
        level_d = 1'b1;
        if (!sync_out) begin
          state_d = RELEASE_WAIT;
          cnt_d   = '0;
        end
      end
      RELEASE_WAIT: begin
        level_d = 1'b1;
        if (sync_out) begin
          state_d = PRESSED;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          cnt_d     = '0;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
        level_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstbtn_n) begin
      sync_q    <= '0;
      state_q   <= IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= sync_d;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

`ifdef LONG_PRESS_EN
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_PRESS_CYCLES);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_PRESS_CYCLES - 1);

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              long_q, long_d;
  logic              holding;

  // Hold time accrues over the whole accepted press, bounces included.
  always_comb begin
    holding = (state_q == PRESSED) || (state_q == RELEASE_WAIT);
    hold_d  = hold_q;
    long_d  = 1'b0;
    if (press_d || !holding) begin
      hold_d = '0;
    end else if (hold_q != HOLD_MAX) begin
      hold_d = hold_q + HOLD_W'(1);
      long_d = (hold_q == HOLD_LAST);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstbtn_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press = long_q;
`else
  logic [31:0] unused_hold_w;
  assign unused_hold_w = HOLD_W;
  assign long_press    = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_btn_debounce.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_btn_debounce: directed plus random bouncing stimulus against a
// run-length reference model of the debouncer.
// Revision: 1.0
// ============================================================================
module tb_btn_debounce;

  localparam int SYNC_STAGES       = 2;
  localparam int DEBOUNCE_CYCLES   = 16;
  localparam int LONG_PRESS_CYCLES = 64;

  logic clk = 1'b0;
  logic rstbtn_n;
  logic btn_raw;
  logic btn_level, btn_press, btn_release, long_press;

  always #5 clk = ~clk;

  btn_debounce #(
    .SYNC_STAGES      (SYNC_STAGES),
    .DEBOUNCE_CYCLES  (DEBOUNCE_CYCLES),
    .LONG_PRESS_CYCLES(LONG_PRESS_CYCLES)
  ) dut (
    .clk        (clk),
    .rstbtn_n   (rstbtn_n),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release),
    .long_press (long_press)
  );

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the value the debouncer sees is btn_raw delayed by the
  // synchroniser; the level flips once that value has disagreed with it on
  // DEBOUNCE_CYCLES+1 consecutive edges.
  bit raw_hist[$];
  bit started = 1'b0;
  bit seen, prev_level;
  bit m_level, m_press, m_rel, m_long;
  int m_run, m_hold, m_edge;

  always @(posedge clk) begin
    if (!rstbtn_n) begin
      raw_hist.delete();
      started = 1'b1;
      m_level = 1'b0; m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      m_run = 0; m_hold = 0; m_edge = 0;
    end else begin
      seen = (raw_hist.size() == SYNC_STAGES) ? raw_hist[0] : 1'b0;
      raw_hist.push_back(btn_raw);
      if (raw_hist.size() > SYNC_STAGES) void'(raw_hist.pop_front());
      m_edge++;
      m_press = 1'b0; m_rel = 1'b0; m_long = 1'b0;
      prev_level = m_level;
      m_run = (seen != m_level) ? m_run + 1 : 0;
      if (m_run == DEBOUNCE_CYCLES + 1) begin
        m_level = seen;
        m_run   = 0;
        if (seen) m_press = 1'b1; else m_rel = 1'b1;
      end
`ifdef LONG_PRESS_EN
      if (!prev_level) m_hold = 0;
      else if (m_hold < LONG_PRESS_CYCLES) begin
        m_hold++;
        if (m_hold == LONG_PRESS_CYCLES) m_long = 1'b1;
      end
      if (m_press) m_hold = 0;
`endif
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %b, expected %b (edge %0d, t=%0t)", nm, act, exp, m_edge, $time);
    end
  endtask

  task automatic lit(input string nm, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  int  press_cnt = 0, rel_cnt = 0, long_cnt = 0, alt_err = 0;
  int  press_edge = -1, rel_edge = -1, long_edge = -1;
  bit  last_was_press = 1'b0;

  always @(negedge clk) begin
    if (started) begin
      vectors++;
      chk("btn_level",   btn_level,   m_level);
      chk("btn_press",   btn_press,   m_press);
      chk("btn_release", btn_release, m_rel);
      chk("long_press",  long_press,  m_long);
      if (m_edge == 0) last_was_press = 1'b0;
      if (btn_press && btn_release) alt_err++;
      if (btn_press === 1'b1) begin
        if (last_was_press) alt_err++;
        last_was_press = 1'b1;
        press_cnt++; press_edge = m_edge;
      end
      if (btn_release === 1'b1) begin
        if (!last_was_press) alt_err++;
        last_was_press = 1'b0;
        rel_cnt++; rel_edge = m_edge;
      end
      if (long_press === 1'b1) begin
        long_cnt++; long_edge = m_edge;
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  localparam int LAT = SYNC_STAGES + DEBOUNCE_CYCLES;

  int p0, r0, l0, fall, n;

  initial begin
    rstbtn_n = 1'b0;
    btn_raw  = 1'b1;
    cyc(3);
    lit("reset_level", int'(btn_level), 0);
    lit("reset_press", int'(btn_press), 0);

    // Held through reset release: full latency, press on edge 19.
    rstbtn_n = 1'b1;
    p0 = press_cnt;
    cyc(25);
    lit("t1_press_count", press_cnt - p0, 1);
    lit("t1_press_edge",  press_edge, 19);
    lit("t1_level",       int'(btn_level), 1);

    // Release with one bounce back high.
    r0 = rel_cnt;
    btn_raw = 1'b0; cyc(5);
    btn_raw = 1'b1; cyc(3);
    btn_raw = 1'b0; fall = m_edge + 1;
    cyc(30);
    lit("t3_release_count", rel_cnt - r0, 1);
    lit("t3_release_edge",  rel_edge, fall + LAT);
    lit("t3_level",         int'(btn_level), 0);

    // Short high burst is rejected.
    p0 = press_cnt; r0 = rel_cnt;
    btn_raw = 1'b1; cyc(10);
    btn_raw = 1'b0; cyc(30);
    lit("t2_press_count",   press_cnt - p0, 0);
    lit("t2_release_count", rel_cnt - r0, 0);

    // Reset while pressed abandons the press silently.
    btn_raw = 1'b1; cyc(25);
    lit("t4_pressed", int'(btn_level), 1);
    r0 = rel_cnt;
    rstbtn_n = 1'b0; cyc(1);
    rstbtn_n = 1'b1;
    lit("t4_level_after_reset", int'(btn_level), 0);
    p0 = press_cnt;
    cyc(25);
    lit("t4_release_count", rel_cnt - r0, 0);
    lit("t4_press_count",   press_cnt - p0, 1);
    lit("t4_press_edge",    press_edge, 19);

    // Long hold.
    btn_raw = 1'b0; cyc(40);
    l0 = long_cnt; p0 = press_cnt;
    btn_raw = 1'b1; cyc(200);
    lit("t5_press_count", press_cnt - p0, 1);
`ifdef LONG_PRESS_EN
    lit("t5_long_count", long_cnt - l0, 1);
    lit("t5_long_delay", long_edge - press_edge, 64);
`else
    lit("t5_long_count", long_cnt - l0, 0);
`endif

    // Two clean presses.
    btn_raw = 1'b0; cyc(40);
    p0 = press_cnt; r0 = rel_cnt;
    repeat (2) begin
      btn_raw = 1'b1; cyc(40);
      btn_raw = 1'b0; cyc(40);
    end
    lit("t6_press_count",   press_cnt - p0, 2);
    lit("t6_release_count", rel_cnt - r0, 2);

    // Random bouncing with occasional long holds and resets.
    repeat (150) begin
      btn_raw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 5))
        0:       n = $urandom_range(17, 40);
        1:       n = $urandom_range(60, 100);
        default: n = $urandom_range(1, 20);
      endcase
      if ($urandom_range(0, 29) == 0) begin
        rstbtn_n = 1'b0; cyc(1);
        rstbtn_n = 1'b1;
      end
      cyc(n);
    end

    lit("pulse_alternation_errors", alt_err, 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
